// File: rtl/imm_narrow_unit.sv
// imm_narrow_unit: narrows signed 16-bit operands to an IMM_W-bit immediate through a 2-entry output FIFO.
// Define IMM_NARROW_SATURATE_EN to clamp out-of-range values instead of truncating them.
module imm_narrow_unit #(
  parameter int IMM_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IMM_W-1:0] out_imm,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             cnt_clr
);
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [IMM_W:0]   h_q, h_d, s_q, s_d, n;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             fit, push, pop;
  logic [IMM_W-1:0] n_imm;
  always_comb begin
    fit = (&in_data[15:IMM_W-1]) | ~(|in_data[15:IMM_W-1]);
`ifdef IMM_NARROW_SATURATE_EN
    n_imm = fit ? in_data[IMM_W-1:0] : {in_data[15], {(IMM_W-1){~in_data[15]}}};
`else
    n_imm = in_data[IMM_W-1:0];
`endif
    n = {~fit, n_imm};
    push = in_valid & rdy_q;
    pop = (cnt_q != 2'd0) & out_ready;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rdy_d = cnt_d != 2'd2;
    // head register doubles as the "last emitted" value while the FIFO is empty
    h_d = (push & ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & pop))) ? n :
          (pop & (cnt_q == 2'd2)) ? s_q : h_q;
    s_d = (push & (cnt_q == 2'd1) & ~pop) ? n : s_q;
    ovf_cnt_d = cnt_clr ? '0 :
                (push & ~fit & ~(&ovf_cnt_q)) ? ovf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : ovf_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      rdy_q     <= 1'b0;
      h_q       <= '0;
      s_q       <= '0;
      ovf_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      h_q       <= h_d;
      s_q       <= s_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end
  assign in_ready  = rdy_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_imm   = h_q[IMM_W-1:0];
  assign out_ovf   = h_q[IMM_W];
  assign ovf_count = ovf_cnt_q;
endmodule

// File: tb/tb_imm_narrow_unit.sv
// tb_imm_narrow_unit: randomized and directed checks of imm_narrow_unit against a queue-based reference model.
module tb_imm_narrow_unit;
  localparam int W = 4;
  localparam int CW = 8;
`ifdef IMM_NARROW_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_ovf;
  logic [W-1:0] out_imm;
  logic [CW-1:0] ovf_count;
  int n_tests = 0, n_fail = 0;
  logic [W:0] q[$];
  logic [W:0] last = '0;
  int cnt_m = 0;
  imm_narrow_unit #(.IMM_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_ovf(out_ovf),
    .ovf_count(ovf_count), .cnt_clr(cnt_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W:0] narrow(input logic [15:0] d);
    int v, lo, hi, r;
    bit ovf;
    logic [31:0] rv;
    v = int'($signed(d));
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    ovf = (v < lo) || (v > hi);
    r = (ovf && SAT) ? ((v < 0) ? lo : hi) : v;
    rv = r;
    return {ovf, rv[W-1:0]};
  endfunction
  task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic clr);
    logic [W:0] e;
    bit push, pop;
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("ovf_count", ovf_count, cnt_m);
    e = (q.size() > 0) ? q[0] : last;
    check("out_imm", out_imm, e[W-1:0]);
    check("out_ovf", out_ovf, e[W]);
    in_valid = iv; in_data = d; out_ready = ordy; cnt_clr = clr;
    push = iv && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    e = narrow(d);
    if (pop) last = q.pop_front();
    if (push) q.push_back(e);
    if (clr) cnt_m = 0;
    else if (push && e[W] && cnt_m < (1 << CW) - 1) cnt_m++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic reset_mid();
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_count", ovf_count, 0);
    check("rst_ready", in_ready, 0);
    q.delete(); last = '0; cnt_m = 0;
    in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    logic [15:0] d;
    #2;
    check("rst0_valid", out_valid, 0);
    check("rst0_ready", in_ready, 0);
    check("rst0_imm", out_imm, 0);
    check("rst0_count", ovf_count, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    step(1, 16'h0003, 1, 0);
    check("t1_imm", out_imm, 4'h3);
    check("t1_ovf", out_ovf, 0);
    step(1, 16'hFFFC, 1, 0);
    check("t2a_imm", out_imm, 4'hC);
    step(1, 16'hFFF8, 1, 0);
    check("t2b_imm", out_imm, 4'h8);
    check("t2b_ovf", out_ovf, 0);
    step(1, 16'h0008, 1, 0);
    check("t3a_imm", out_imm, SAT ? 4'h7 : 4'h8);
    check("t3a_ovf", out_ovf, 1);
    check("t3a_count", ovf_count, 1);
    step(1, 16'h8000, 1, 0);
    check("t3b_imm", out_imm, SAT ? 4'h8 : 4'h0);
    check("t3b_ovf", out_ovf, 1);
    step(0, 16'h0000, 1, 0);
    step(1, 16'h0001, 0, 0);
    step(1, 16'h0002, 0, 0);
    check("t4_full", in_ready, 0);
    check("t4_hold", out_imm, 4'h1);
    step(1, 16'h0003, 0, 0);
    check("t4_hold2", out_imm, 4'h1);
    step(1, 16'h0003, 1, 0);
    check("t4_second", out_imm, 4'h2);
    step(1, 16'h0003, 1, 0);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 1, 0);
    for (int i = 0; i < 260; i++) step(1, 16'h0100, 1, 0);
    check("t5_sat", ovf_count, 8'hFF);
    step(0, 16'h0000, 1, 1);
    check("t5_clr", ovf_count, 8'h00);
    step(1, 16'h0100, 1, 1);
    check("t5_clr_pri", ovf_count, 8'h00);
    step(0, 16'h0000, 1, 0);
    step(1, 16'h0100, 0, 0);
    step(1, 16'h0200, 0, 0);
    check("t6_full", out_valid, 1);
    reset_mid();
    check("t6_ready", in_ready, 1);
    step(1, 16'h0005, 1, 0);
    check("t6_imm", out_imm, 4'h5);
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($signed($urandom_range(0, 31)) - 16);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    end
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h0000, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
